// File: rtl/mouse_canvas_if.sv
// Mouse packet inputs and canvas outputs of mouse_canvas, bundled for port connection.
// The master side produces packets and control; the slave side is the canvas.
interface mouse_canvas_if #(
  parameter int GRID_W  = 30,
  parameter int GRID_H  = 30,
  parameter int DELTA_W = 9
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int CW = $clog2(GRID_W * GRID_H + 1);

  logic                      valid;
  logic signed [DELTA_W-1:0] dx;
  logic signed [DELTA_W-1:0] dy;
  logic                      lmb;
  logic                      rmb;
  logic                      clear;
  logic                      freeze;
  logic [GRID_W*GRID_H-1:0]  bitmap;
  logic [XW-1:0]             cur_x;
  logic [YW-1:0]             cur_y;
  logic [CW-1:0]             count;
  logic                      busy;

  modport master (
    output valid, dx, dy, lmb, rmb, clear, freeze,
    input  bitmap, cur_x, cur_y, count, busy
  );

  modport slave (
    input  valid, dx, dy, lmb, rmb, clear, freeze,
    output bitmap, cur_x, cur_y, count, busy
  );
endinterface

// File: rtl/mouse_canvas.sv
// Handwriting canvas: saturating sub-cell mouse cursor that paints a cell bitmap
// while the left button is held; a row-per-cycle wipe runs on right button or clear.
module mouse_canvas #(
  parameter int GRID_W  = 30,
  parameter int GRID_H  = 30,
  parameter int SHIFT   = 3,
  parameter int DELTA_W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mouse_canvas_if.slave bus
);
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int PXW   = XW + SHIFT;
  localparam int PYW   = YW + SHIFT;
  localparam int CELLS = GRID_W * GRID_H;
  localparam int IW    = $clog2(CELLS);
  localparam int CW    = $clog2(CELLS + 1);
  localparam int MW    = (PXW > PYW) ? PXW : PYW;
  // Two guard bits above the wider operand keep the sum free of wrap-around.
  localparam int SW    = ((MW > DELTA_W) ? MW : DELTA_W) + 2;

  localparam logic signed [SW-1:0] MAX_X = SW'(GRID_W * (2 ** SHIFT) - 1);
  localparam logic signed [SW-1:0] MAX_Y = SW'(GRID_H * (2 ** SHIFT) - 1);
  localparam logic [PXW-1:0] RST_X = PXW'((GRID_W / 2) * (2 ** SHIFT));
  localparam logic [PYW-1:0] RST_Y = PYW'((GRID_H / 2) * (2 ** SHIFT));

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic            pend;
  logic            busy;
  logic [YW-1:0]   row;
  logic [PXW-1:0]  pos_x;
  logic [PYW-1:0]  pos_y;
  logic [CELLS-1:0] bitmap;
  logic [CW-1:0]   count;

  logic signed [SW-1:0] sum_x;
  logic signed [SW-1:0] sum_y;
  logic [PXW-1:0]  pos_x_nx;
  logic [PYW-1:0]  pos_y_nx;
  logic [IW-1:0]   paint_idx;
  logic [IW-1:0]   row_base;
  logic            req;
  logic            paint;

  function automatic logic signed [SW-1:0] sat(input logic signed [SW-1:0] v,
                                               input logic signed [SW-1:0] hi);
    if (v[SW-1])     return '0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  always_comb begin
    sum_x = signed'({{(SW-PXW){1'b0}}, pos_x})
          + signed'({{(SW-DELTA_W){bus.dx[DELTA_W-1]}}, bus.dx});
    // +dy is upward motion, and row 0 is the top row, so dy is subtracted.
    sum_y = signed'({{(SW-PYW){1'b0}}, pos_y})
          - signed'({{(SW-DELTA_W){bus.dy[DELTA_W-1]}}, bus.dy});
    pos_x_nx  = PXW'(sat(sum_x, MAX_X));
    pos_y_nx  = PYW'(sat(sum_y, MAX_Y));
    paint_idx = IW'(pos_y_nx[PYW-1:SHIFT]) * IW'(GRID_W) + IW'(pos_x_nx[PXW-1:SHIFT]);
    row_base  = IW'(row) * IW'(GRID_W);
    req       = (bus.valid & bus.rmb) | bus.clear;
    paint     = bus.valid & bus.lmb & ~bus.rmb & ~bus.clear & ~bus.freeze & (state == IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      pend   <= 1'b0;
      busy   <= 1'b0;
      row    <= '0;
      pos_x  <= RST_X;
      pos_y  <= RST_Y;
      bitmap <= '0;
      count  <= '0;
    end else begin
      if (bus.valid) begin
        pos_x <= pos_x_nx;
        pos_y <= pos_y_nx;
      end
      case (state)
        IDLE: begin
          if (!bus.freeze && (req || pend)) begin
            state <= CLEAR;
            row   <= '0;
            pend  <= 1'b0;
            busy  <= 1'b1;
          end else begin
            if (req) pend <= 1'b1;
            if (paint) begin
              bitmap[paint_idx] <= 1'b1;
              if (!bitmap[paint_idx]) count <= count + 1'b1;
            end
          end
        end
        CLEAR: begin
          // A running wipe pauses while frozen; new requests merge into it.
          if (!bus.freeze) begin
            bitmap[row_base +: GRID_W] <= '0;
            if (row == YW'(GRID_H - 1)) begin
              count <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bitmap = bitmap;
  assign bus.cur_x  = pos_x[PXW-1:SHIFT];
  assign bus.cur_y  = pos_y[PYW-1:SHIFT];
  assign bus.count  = count;
  assign bus.busy   = busy;
endmodule

// File: tb/tb_mouse_canvas.sv
// Directed bench for mouse_canvas: vector table for cursor/paint/saturation,
// hand-written sequences for clear, freeze and reset during a clear.
module tb_mouse_canvas;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mouse_canvas_if #(.GRID_W(30), .GRID_H(30), .DELTA_W(9)) bus ();

  mouse_canvas #(.GRID_W(30), .GRID_H(30), .SHIFT(3), .DELTA_W(9)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic valid; int dx; int dy; logic lmb; logic rmb;
    int ex; int ey; int ecnt; int bidx; logic ebit;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_pkt(input int dx, input int dy, input logic lmb, input logic rmb);
    bus.valid = 1'b1;
    bus.dx    = 9'(dx);
    bus.dy    = 9'(dy);
    bus.lmb   = lmb;
    bus.rmb   = rmb;
  endtask

  task automatic idle_inputs();
    bus.valid = 1'b0;
    bus.dx    = '0;
    bus.dy    = '0;
    bus.lmb   = 1'b0;
    bus.rmb   = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    //            valid dx    dy    lmb rmb  ex  ey cnt  bidx bit
    vt[0]  = '{1'b1,   16,    0, 1'b1, 1'b0, 17, 15, 1, 467, 1'b1};
    vt[1]  = '{1'b1,    0,    0, 1'b1, 1'b0, 17, 15, 1, 467, 1'b1};
    vt[2]  = '{1'b1, -256,    0, 1'b0, 1'b0,  0, 15, 1, 467, 1'b1};
    vt[3]  = '{1'b1, -256,    0, 1'b0, 1'b0,  0, 15, 1, 467, 1'b1};
    vt[4]  = '{1'b1, -256,    0, 1'b0, 1'b0,  0, 15, 1, 467, 1'b1};
    vt[5]  = '{1'b1, -256,    0, 1'b0, 1'b0,  0, 15, 1, 467, 1'b1};
    vt[6]  = '{1'b1, -256,    0, 1'b0, 1'b0,  0, 15, 1, 450, 1'b0};
    vt[7]  = '{1'b1,    8,    0, 1'b0, 1'b0,  1, 15, 1, 451, 1'b0};
    vt[8]  = '{1'b1,   -8,    0, 1'b0, 1'b0,  0, 15, 1, 450, 1'b0};
    vt[9]  = '{1'b1,  255,    0, 1'b0, 1'b0, 29, 15, 1, 479, 1'b0};
    vt[10] = '{1'b1,   -8,    0, 1'b0, 1'b0, 28, 15, 1, 478, 1'b0};
    vt[11] = '{1'b1,    8,    0, 1'b0, 1'b0, 29, 15, 1, 479, 1'b0};
    vt[12] = '{1'b1,    0,    8, 1'b0, 1'b0, 29, 14, 1, 449, 1'b0};
    vt[13] = '{1'b1,    0,   -8, 1'b0, 1'b0, 29, 15, 1, 479, 1'b0};
    vt[14] = '{1'b1,    0, -255, 1'b1, 1'b0, 29, 29, 2, 899, 1'b1};
    vt[15] = '{1'b1,    0,  255, 1'b1, 1'b0, 29,  0, 3,  29, 1'b1};
    vt[16] = '{1'b0,   16,    0, 1'b1, 1'b0, 29,  0, 3,  28, 1'b0};

    idle_inputs();
    bus.freeze = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_cur_x", int'(bus.cur_x), 15);
    chk("rst_cur_y", int'(bus.cur_y), 15);
    chk("rst_bitmap_zero", int'(bus.bitmap == '0), 1);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      drive_pkt(vt[i].dx, vt[i].dy, vt[i].lmb, vt[i].rmb);
      bus.valid = vt[i].valid;
      tick();
      idle_inputs();
      chk($sformatf("v%0d_cur_x", i), int'(bus.cur_x), vt[i].ex);
      chk($sformatf("v%0d_cur_y", i), int'(bus.cur_y), vt[i].ey);
      chk($sformatf("v%0d_count", i), int'(bus.count), vt[i].ecnt);
      chk($sformatf("v%0d_busy", i), int'(bus.busy), 0);
      chk($sformatf("v%0d_bit%0d", i, vt[i].bidx), int'(bus.bitmap[vt[i].bidx]), int'(vt[i].ebit));
    end

    // rmb+lmb in one packet: clear wins, cursor still moves to (28,0)
    @(negedge clk);
    drive_pkt(-8, 0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("clr_start_busy", int'(bus.busy), 1);
    chk("clr_start_cur_x", int'(bus.cur_x), 28);
    chk("clr_start_no_paint", int'(bus.bitmap[28]), 0);
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      if (bus.busy) busy_cnt++;
      if (i == 4) drive_pkt(-8, 0, 1'b1, 1'b0);
      tick();
      if (i == 4) begin
        idle_inputs();
        chk("clr_mid_cur_x", int'(bus.cur_x), 27);
        chk("clr_mid_no_paint", int'(bus.bitmap[27]), 0);
      end
    end
    chk("clr_busy_cycles", busy_cnt, 30);
    chk("clr_bitmap_zero", int'(bus.bitmap == '0), 1);
    chk("clr_count", int'(bus.count), 0);

    // freeze blocks painting and defers a clear
    @(negedge clk);
    bus.freeze = 1'b1;
    drive_pkt(0, 0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    chk("frz_no_paint", int'(bus.bitmap[27]), 0);
    chk("frz_count", int'(bus.count), 0);
    @(negedge clk);
    bus.clear = 1'b1;
    tick();
    idle_inputs();
    chk("frz_clear_busy0", int'(bus.busy), 0);
    tick();
    chk("frz_clear_busy0_b", int'(bus.busy), 0);
    @(negedge clk);
    bus.freeze = 1'b0;
    tick();
    chk("pend_busy_rise", int'(bus.busy), 1);
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      if (bus.busy) busy_cnt++;
      tick();
    end
    chk("pend_busy_cycles", busy_cnt, 30);

    @(negedge clk);
    drive_pkt(0, 0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    chk("unfrz_paint", int'(bus.bitmap[27]), 1);
    chk("unfrz_count", int'(bus.count), 1);

    // reset at busy cycle 10 aborts the clear
    @(negedge clk);
    bus.clear = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 9; i++) tick();
    chk("rstmid_busy_before", int'(bus.busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("rstmid_busy", int'(bus.busy), 0);
    chk("rstmid_cur_x", int'(bus.cur_x), 15);
    chk("rstmid_cur_y", int'(bus.cur_y), 15);
    chk("rstmid_count", int'(bus.count), 0);
    chk("rstmid_bitmap_zero", int'(bus.bitmap == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstmid_stays_idle", int'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
